// File: rtl/spi_ram_ctrl_if.sv
// Word bus between the SPI slave (master side) and the command-decoding RAM (slave side).
// Handshake: rx_valid is a one-cycle strobe that qualifies rx_data; there is no ready, so
// every strobed word is consumed. tx_valid qualifies tx_data and stays high until the next consumed command.
interface spi_ram_ctrl_if;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  modport master (output rx_data, output rx_valid, input tx_data, input tx_valid);
  modport slave  (input rx_data, input rx_valid, output tx_data, output tx_valid);
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave: address loads, writes and read fetches.
// Optional feature: define SPI_RAM_AUTOINC_EN to post-increment the address after each data access.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_ctrl_if.slave        bus,
    output logic [ADDR_SIZE-1:0] dbg_wr_addr,
    output logic [ADDR_SIZE-1:0] dbg_rd_addr
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);
    localparam logic [31:0] LAST_W  = 32'(MEM_DEPTH - 1);

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;

    cmd_t                 cmd;
    logic [ADDR_SIZE-1:0] payload_addr;
    logic [7:0]           payload_byte;
    logic                 wr_in_range;
    logic                 rd_in_range;

    assign cmd          = cmd_t'(bus.rx_data[9:8]);
    assign payload_addr = bus.rx_data[ADDR_SIZE-1:0];
    assign payload_byte = bus.rx_data[7:0];
    assign wr_in_range  = 32'(wr_addr) < DEPTH_W;
    assign rd_in_range  = 32'(rd_addr) < DEPTH_W;

`ifdef SPI_RAM_AUTOINC_EN
    // Wrap compares against the last legal word so non-power-of-2 depths wrap correctly.
    function automatic logic [ADDR_SIZE-1:0] bump(input logic [ADDR_SIZE-1:0] a);
        if (32'(a) == LAST_W) return '0;
        return a + ADDR_SIZE'(1);
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
        end else if (bus.rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr    <= payload_addr;
                    tx_valid_q <= 1'b0;
                end
                CMD_WR_DATA: begin
`ifdef SPI_RAM_AUTOINC_EN
                    wr_addr    <= bump(wr_addr);
`endif
                    tx_valid_q <= 1'b0;
                end
                CMD_RD_ADDR: begin
                    rd_addr    <= payload_addr;
                    tx_valid_q <= 1'b0;
                end
                CMD_RD_DATA: begin
                    // Out-of-range reads still complete, returning zero.
                    tx_data_q  <= rd_in_range ? mem[rd_addr] : 8'h00;
                    tx_valid_q <= 1'b1;
`ifdef SPI_RAM_AUTOINC_EN
                    rd_addr    <= bump(rd_addr);
`endif
                end
                default: tx_valid_q <= 1'b0;
            endcase
        end
    end

    // Storage is deliberately not reset; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (bus.rx_valid && cmd == CMD_WR_DATA && wr_in_range) begin
            mem[wr_addr] <= payload_byte;
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign dbg_wr_addr  = wr_addr;
    assign dbg_rd_addr  = rd_addr;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Randomized bench for spi_ram_ctrl with a behavioural memory model and per-cycle output compare.
// The DUT uses a 200-word memory so payload addresses 200..255 exercise the out-of-range path.
module tb_spi_ram_ctrl;
  localparam int DEPTH = 200;
  localparam int ASZ   = 8;

  logic clk = 1'b0;
  logic rst;
  logic [ASZ-1:0] dbg_wr_addr;
  logic [ASZ-1:0] dbg_rd_addr;

  spi_ram_ctrl_if bus ();

  spi_ram_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SIZE(ASZ)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_wr_addr(dbg_wr_addr),
    .dbg_rd_addr(dbg_rd_addr)
  );

  always #5 clk = ~clk;

`ifdef SPI_RAM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  // Behavioural model: a plain array plus two address integers.
  int m_mem [DEPTH];
  int m_wr, m_rd, m_tx_data;
  bit m_tx_valid;

  function automatic int next_addr(input int a);
    if (a == DEPTH - 1) return 0;
    return (a + 1) % (1 << ASZ);
  endfunction

  always @(posedge clk or posedge rst) begin
    int c;
    int p;
    if (rst) begin
      m_wr = 0; m_rd = 0; m_tx_data = 0; m_tx_valid = 1'b0;
    end else if (bus.rx_valid === 1'b1) begin
      c = int'(bus.rx_data[9:8]);
      p = int'(bus.rx_data[7:0]);
      if (c == 0) begin
        m_wr = p % (1 << ASZ); m_tx_valid = 1'b0;
      end else if (c == 1) begin
        if (m_wr < DEPTH) m_mem[m_wr] = p;
        if (AUTOINC) m_wr = next_addr(m_wr);
        m_tx_valid = 1'b0;
      end else if (c == 2) begin
        m_rd = p % (1 << ASZ); m_tx_valid = 1'b0;
      end else begin
        m_tx_data = (m_rd < DEPTH) ? m_mem[m_rd] : 0;
        m_tx_valid = 1'b1;
        if (AUTOINC) m_rd = next_addr(m_rd);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outputs only change on posedge or rst, so the falling edge is a quiet sampling point.
  always @(negedge clk) begin
    if (checking) begin
      check("tx_valid", 32'(bus.tx_valid), 32'(m_tx_valid));
      check("tx_data", 32'(bus.tx_data), 32'(m_tx_data));
      check("wr_addr", 32'(dbg_wr_addr), 32'(m_wr));
      check("rd_addr", 32'(dbg_rd_addr), 32'(m_rd));
    end
  end

  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = {c, p};
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 10'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 10'h000;
    repeat (2) @(negedge clk);
    check("reset_tx_valid", 32'(bus.tx_valid), 32'h0);
    check("reset_tx_data", 32'(bus.tx_data), 32'h00);
    check("reset_wr_addr", 32'(dbg_wr_addr), 32'h0);
    check("reset_rd_addr", 32'(dbg_rd_addr), 32'h0);
    rst = 1'b0;
    checking = 1'b1;

    // Preload every legal word with a known pattern.
    for (int a = 0; a < DEPTH; a++) begin
      cmd(2'b00, 8'(a));
      cmd(2'b01, 8'(a) ^ 8'h5A);
    end
    idle(1);

    // Write then read back a single byte; hold for 8 idle cycles.
    cmd(2'b00, 8'h3C);
    cmd(2'b01, 8'hA5);
    cmd(2'b10, 8'h3C);
    cmd(2'b11, 8'h00);
    idle(1);
    for (int i = 0; i < 8; i++) begin
      check("rd_hold_valid", 32'(bus.tx_valid), 32'h1);
      check("rd_hold_data", 32'(bus.tx_data), 32'hA5);
      idle(1);
    end

    // Any non-read command clears tx_valid but keeps tx_data.
    cmd(2'b00, 8'h10);
    idle(1);
    check("clear_valid", 32'(bus.tx_valid), 32'h0);
    check("clear_data_kept", 32'(bus.tx_data), 32'hA5);
    cmd(2'b11, 8'h00);
    idle(1);
    check("reread_valid", 32'(bus.tx_valid), 32'h1);
    cmd(2'b11, 8'h00);
    cmd(2'b11, 8'h00);
    idle(1);
    check("b2b_read_valid", 32'(bus.tx_valid), 32'h1);

    // Out of range write is dropped, read returns zero with valid.
    cmd(2'b00, 8'hC8);
    cmd(2'b01, 8'h55);
    cmd(2'b10, 8'hC8);
    cmd(2'b11, 8'h00);
    idle(1);
    check("oor_data", 32'(bus.tx_data), 32'h00);
    check("oor_valid", 32'(bus.tx_valid), 32'h1);
    cmd(2'b10, 8'h00);
    cmd(2'b11, 8'h00);
    idle(1);
    check("mem0_intact", 32'(bus.tx_data), 32'h5A);

    // Two writes and two reads starting at the last legal word.
    cmd(2'b00, 8'(DEPTH - 1));
    cmd(2'b01, 8'h11);
    cmd(2'b01, 8'h22);
    cmd(2'b10, 8'(DEPTH - 1));
    cmd(2'b11, 8'h00);
    idle(1);
    check("wrap_read1", 32'(bus.tx_data), AUTOINC ? 32'h11 : 32'h22);
    cmd(2'b11, 8'h00);
    idle(1);
    check("wrap_read2", 32'(bus.tx_data), 32'h22);

    // Reset during an active read drops tx_valid without a clock edge.
    cmd(2'b10, 8'h3C);
    cmd(2'b11, 8'h00);
    idle(1);
    check("pre_rst_valid", 32'(bus.tx_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.tx_valid), 32'h0);
    check("async_rst_data", 32'(bus.tx_data), 32'h00);
    check("async_rst_wr", 32'(dbg_wr_addr), 32'h0);
    check("async_rst_rd", 32'(dbg_rd_addr), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Random soak with random gaps.
    for (int n = 0; n < 10000; n++) begin
      cmd(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(3);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
